ped_request_scheduler: RTL and testbench

//  Front end for the traffic light controller's single pedestrian_request input. Debounces
//  N crosswalk buttons, holds a pending flag per button, and issues one-cycle request pulses.

---
 rtl/tlc_pkg.sv | 30 +++
 rtl/ped_button_debounce.sv | 42 ++++
 rtl/ped_request_scheduler.sv | 149 ++++++++++++++
 tb/tb_ped_request_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared encodings for the traffic light controller and its pedestrian
// request scheduler.
//  - ctl_state_t   : controller current_state codes
//  - sched_state_t : pedestrian scheduler FSM states
//  - is_yellow()   : true for the controller's latch-clear (yellow) states
package tlc_pkg;

  typedef enum logic [2:0] {
    S_NS_GREEN  = 3'b000,
    S_NS_YELLOW = 3'b001,
    S_EW_GREEN  = 3'b010,
    S_EW_YELLOW = 3'b011,
    S_PED_GREEN = 3'b100
  } ctl_state_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQUEST   = 3'd1,
    WAIT_WALK = 3'd2,
    WALK      = 3'd3,
    COOLDOWN  = 3'd4
  } sched_state_t;

  localparam int STAT_W = 16;

  function automatic logic is_yellow(input logic [2:0] s);
    return (s == S_NS_YELLOW) || (s == S_EW_YELLOW);
  endfunction

endpackage

// File: rtl/ped_button_debounce.sv
// One crosswalk button: 2-FF synchronizer, consecutive-high counter and a
// single-cycle accept pulse.
//  clk, reset : clock, synchronous active-high reset
//  btn        : raw asynchronous button level
//  accept     : one-cycle pulse in the cycle the counter reaches DEBOUNCE_CYCLES
// The counter saturates at DEBOUNCE_CYCLES and only clears when the
// synchronized level drops, so a long press yields exactly one accept.
module ped_button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic accept
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_PRE = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      accept <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      if (!sync2)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
      // registered so the pulse lines up with cnt == CNT_MAX
      accept <= sync2 && (cnt == CNT_PRE);
    end
  end

endmodule

// File: rtl/ped_request_scheduler.sv
// Pedestrian request front end for the traffic light controller.
// Debounces N_BUTTONS crosswalk buttons, keeps a pending flag per button,
// issues one-cycle ped_request pulses, watches the controller state for the
// walk phase and enforces a MIN_GAP vehicle-service gap between walks.
//  clk, reset  : clock, synchronous active-high reset
//  btn         : raw button levels
//  ctl_state   : controller current_state (tlc_pkg codes)
//  ped_request : one-cycle request pulse to the controller
//  pending     : accepted, not yet served presses
//  served      : one-cycle snapshot of pending at walk end
//  walk_active : FSM in WALK
//  cooldown    : FSM in COOLDOWN
// Optional feature macro PED_STATS_EN adds walk_count / last_wait outputs,
// both updated on the WALK entry edge and saturating at 16'hFFFF.
module ped_request_scheduler
  import tlc_pkg::*;
#(
  parameter int N_BUTTONS       = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MIN_GAP         = 20,
  parameter int WAIT_TIMEOUT    = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_BUTTONS-1:0] btn,
  input  logic [2:0]           ctl_state,
  output logic                 ped_request,
  output logic [N_BUTTONS-1:0] pending,
  output logic [N_BUTTONS-1:0] served,
  output logic                 walk_active,
  output logic                 cooldown
`ifdef PED_STATS_EN
  ,
  output logic [STAT_W-1:0]    walk_count,
  output logic [STAT_W-1:0]    last_wait
`endif
);

  localparam int TW = $clog2(WAIT_TIMEOUT + 1);
  localparam int GW = $clog2(MIN_GAP + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(WAIT_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(MIN_GAP - 1);

  sched_state_t         state, state_n;
  logic [TW-1:0]        tcnt;
  logic [GW-1:0]        gcnt;
  logic [N_BUTTONS-1:0] accept;
  logic                 ped_green, walk_exit, walk_enter;

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_btn
    ped_button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .btn   (btn[i]),
      .accept(accept[i])
    );
  end

  // unknown codes fall out as "not PED_GREEN"
  assign ped_green  = (ctl_state == S_PED_GREEN);
  assign walk_exit  = (state == WALK) && !ped_green;
  assign walk_enter = (state != WALK) && (state_n == WALK);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      // a walk the controller grants on its own is tracked like ours
      IDLE:      if (ped_green) state_n = WALK;
                 else if (|pending) state_n = REQUEST;
      REQUEST:   state_n = WAIT_WALK;
      // no re-pulse during yellow: the controller clears its latch then
      WAIT_WALK: if (ped_green) state_n = WALK;
                 else if (tcnt == TO_LAST && !is_yellow(ctl_state)) state_n = REQUEST;
      WALK:      if (!ped_green) state_n = COOLDOWN;
      COOLDOWN:  if (ped_green) state_n = WALK;
                 else if (gcnt == GAP_LAST) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // counters clear outside their state and hold at the terminal count
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt <= '0;
      gcnt <= '0;
    end else begin
      if (state != WAIT_WALK)  tcnt <= '0;
      else if (tcnt != TO_LAST) tcnt <= tcnt + 1'b1;
      if (state != COOLDOWN)    gcnt <= '0;
      else if (gcnt != GAP_LAST) gcnt <= gcnt + 1'b1;
    end
  end

  // accepts during WALK are absorbed, except on the exit edge where a
  // fresh press survives the clear and stays pending
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      served  <= '0;
    end else begin
      served <= '0;
      if (walk_exit) begin
        served  <= pending;
        pending <= accept;
      end else if (state != WALK) begin
        pending <= pending | accept;
      end
    end
  end

  assign ped_request = (state == REQUEST);
  assign walk_active = (state == WALK);
  assign cooldown    = (state == COOLDOWN);

`ifdef PED_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = '1;
  logic [STAT_W-1:0] wait_cnt;

  // wait_cnt starts at 1 on the REQUEST entry edge so that its value just
  // before the WALK entry edge equals the elapsed cycle count
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt   <= '0;
      walk_count <= '0;
      last_wait  <= '0;
    end else begin
      if (state == IDLE && state_n == REQUEST)
        wait_cnt <= STAT_W'(1);
      else if ((state == REQUEST || state == WAIT_WALK) && wait_cnt != STAT_MAX)
        wait_cnt <= wait_cnt + 1'b1;
      if (walk_enter) begin
        if (walk_count != STAT_MAX) walk_count <= walk_count + 1'b1;
        last_wait <= (state == WAIT_WALK) ? wait_cnt : '0;
      end
    end
  end
`else
  logic unused_walk_enter;
  assign unused_walk_enter = walk_enter;
`endif

endmodule

// File: tb/tb_ped_request_scheduler.sv
// Directed scenarios plus randomized buttons/controller traffic, all checked
// against a behavioural model that works from raw button history windows
// and the scheduler's state rules.
module tb_ped_request_scheduler;
  import tlc_pkg::*;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int MG = 20;
  localparam int WT = 64;
  localparam int M_IDLE = 0, M_REQ = 1, M_WAIT = 2, M_WALK = 3, M_COOL = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] btn;
  logic [2:0]   ctl_state, ctl_man, ctl_auto;
  logic         auto_en;
  logic         ped_request, walk_active, cooldown;
  logic [N-1:0] pending, served;
`ifdef PED_STATS_EN
  logic [15:0]  walk_count, last_wait;
`endif

  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;
  assign ctl_state = auto_en ? ctl_auto : ctl_man;

  ped_request_scheduler #(
    .N_BUTTONS(N), .DEBOUNCE_CYCLES(D), .MIN_GAP(MG), .WAIT_TIMEOUT(WT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn        (btn),
    .ctl_state  (ctl_state),
    .ped_request(ped_request),
    .pending    (pending),
    .served     (served),
    .walk_active(walk_active),
    .cooldown   (cooldown)
`ifdef PED_STATS_EN
    ,
    .walk_count (walk_count),
    .last_wait  (last_wait)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  // hist[k] = raw button sample taken k edges ago. A press is accepted
  // (pending set) on the edge where samples 3..D+2 ago are all high and the
  // one before that run was low: 2 sync stages + D counts + accept register.
  logic [N-1:0] hist [0:D+3];
  logic [N-1:0] m_pend, m_serv, acc;
  int           m_st, nst, tc, gc;
  logic         chk_en = 1'b0, m_pg, m_yel, m_exit;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      for (int k = 0; k <= D + 3; k++) hist[k] = '0;
      m_st = M_IDLE; m_pend = '0; m_serv = '0; tc = 0; gc = 0;
      chk_en = 1'b1;
    end else begin
      for (int k = D + 3; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = btn;
      for (int i = 0; i < N; i++) begin
        acc[i] = !hist[D+3][i];
        for (int k = 3; k < D + 3; k++) if (!hist[k][i]) acc[i] = 1'b0;
      end
      m_pg   = (ctl_state == 3'b100);
      m_yel  = (ctl_state == 3'b001) || (ctl_state == 3'b011);
      m_serv = '0;
      m_exit = 1'b0;
      nst    = m_st;
      case (m_st)
        M_IDLE: if (m_pg) nst = M_WALK; else if (m_pend != 0) nst = M_REQ;
        M_REQ:  begin nst = M_WAIT; tc = 0; end
        M_WAIT: if (m_pg) nst = M_WALK;
                else if (tc == WT - 1) begin if (!m_yel) nst = M_REQ; end
                else tc++;
        M_WALK: if (!m_pg) begin nst = M_COOL; gc = 0; m_exit = 1'b1; end
        default: if (m_pg) nst = M_WALK; else if (gc == MG - 1) nst = M_IDLE; else gc++;
      endcase
      if (m_exit) begin m_serv = m_pend; m_pend = acc; end
      else if (m_st != M_WALK) m_pend = m_pend | acc;
      m_st = nst;
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("m_ped_request", 32'(ped_request), 32'(m_st == M_REQ));
      chk("m_walk_active", 32'(walk_active), 32'(m_st == M_WALK));
      chk("m_cooldown",    32'(cooldown),    32'(m_st == M_COOL));
      chk("m_pending",     32'(pending),     32'(m_pend));
      chk("m_served",      32'(served),      32'(m_serv));
    end
  end

  // ---------------- random controller stand-in ----------------
  int   ph = 0, ph_len = 10;
  logic req_seen = 1'b0;

  initial forever begin
    @(negedge clk);
    if (!auto_en) begin
      ctl_auto = S_NS_GREEN; ph = 0; req_seen = 1'b0;
    end else begin
      // some requests are dropped so the timeout path gets exercised
      if (ped_request && $urandom_range(0, 3) != 0) req_seen = 1'b1;
      ph++;
      case (ctl_auto)
        S_NS_GREEN, S_EW_GREEN:
          if (ph >= ph_len) begin
            ctl_auto = (ctl_auto == S_NS_GREEN) ? S_NS_YELLOW : S_EW_YELLOW; ph = 0;
          end else if ($urandom_range(0, 149) == 0) begin
            ctl_auto = S_PED_GREEN; ph = 0; ph_len = $urandom_range(2, 6);
          end else if ($urandom_range(0, 99) == 0) begin
            ctl_auto = 3'b110;
          end
        S_NS_YELLOW, S_EW_YELLOW:
          if (ph >= 2) begin
            if (req_seen) begin
              ctl_auto = S_PED_GREEN; req_seen = 1'b0; ph_len = $urandom_range(2, 8);
            end else begin
              ctl_auto = (ctl_auto == S_NS_YELLOW) ? S_EW_GREEN : S_NS_GREEN;
              ph_len = $urandom_range(6, 30);
            end
            ph = 0;
          end
        S_PED_GREEN:
          if (ph >= ph_len) begin
            ctl_auto = S_NS_GREEN; ph = 0; ph_len = $urandom_range(6, 30);
          end
        default: begin ctl_auto = S_NS_GREEN; ph = 0; end
      endcase
    end
  end

  // ---------------- stimulus ----------------
  int hold [N];
  int np, got;

  initial begin
    reset = 1'b1; btn = '0; ctl_man = S_NS_GREEN; auto_en = 1'b0;
    repeat (3) tick();
    chk("rst_ped_request", 32'(ped_request), 32'd0);
    chk("rst_pending",     32'(pending),     32'd0);
    chk("rst_served",      32'(served),      32'd0);
    chk("rst_walk_active", 32'(walk_active), 32'd0);
    chk("rst_cooldown",    32'(cooldown),    32'd0);
    reset = 1'b0;
    tick();

    // 1: single press, latency and one pulse
    btn[2] = 1'b1;
    repeat (6) tick();
    chk("t1_pend_e6", 32'(pending), 32'd0);
    tick();
    chk("t1_pend_e7", 32'(pending), 32'b0100);
    chk("t1_req_e7",  32'(ped_request), 32'd0);
    tick();
    chk("t1_req_e8",  32'(ped_request), 32'd1);
    tick();
    chk("t1_req_e9",  32'(ped_request), 32'd0);
    tick();
    btn[2] = 1'b0;
    ctl_man = S_PED_GREEN;
    repeat (4) tick();
    chk("t1_walk", 32'(walk_active), 32'd1);
    ctl_man = S_NS_GREEN;
    tick();
    chk("t1_served", 32'(served), 32'b0100);
    chk("t1_cool",   32'(cooldown), 32'd1);
    repeat (25) tick();

    // 2: glitch shorter than the debounce window
    btn[0] = 1'b1;
    repeat (2) tick();
    btn[0] = 1'b0;
    np = 0;
    repeat (15) begin tick(); if (ped_request) np++; end
    chk("t2_pend",   32'(pending), 32'd0);
    chk("t2_pulses", 32'(np), 32'd0);

    // 3: two buttons one cycle apart -> one request
    btn[1] = 1'b1; tick(); btn[3] = 1'b1;
    np = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (ped_request) np++;
      if (k == 8) btn = '0;
    end
    chk("t3_pulses", 32'(np), 32'd1);
    chk("t3_pend",   32'(pending), 32'b1010);
    ctl_man = S_PED_GREEN;
    repeat (5) tick();
    ctl_man = S_NS_GREEN;
    tick();
    chk("t3_served",     32'(served), 32'b1010);
    chk("t3_pend_clear", 32'(pending), 32'd0);
    repeat (25) tick();

    // 4: foreign walk, press absorbed in WALK, press in COOLDOWN
    ctl_man = S_PED_GREEN;
    tick();
    btn[0] = 1'b1;
    repeat (12) tick();
    btn[0] = 1'b0;
    repeat (2) tick();
    chk("t4_walk",      32'(walk_active), 32'd1);
    chk("t4_absorbed",  32'(pending), 32'd0);
    ctl_man = S_NS_GREEN;
    got = 0;
    for (int k = 1; k <= 30 && got == 0; k++) begin
      tick();
      if (k == 2)  btn[0] = 1'b1;
      if (k == 11) btn[0] = 1'b0;
      if (k == 12) chk("t4_cool_pend", 32'(pending), 32'b0001);
      if (ped_request) got = k;
    end
    chk("t4_gap", 32'(got), 32'(MG + 2));

    // 5: timeout re-pulse, then deferral over yellow
    got = 0;
    for (int j = 1; j <= 120 && got == 0; j++) begin
      tick();
      if (ped_request) got = j;
    end
    chk("t5_timeout", 32'(got), 32'(WT + 1));
    got = 0;
    for (int j = 1; j <= 120 && got == 0; j++) begin
      tick();
      if (ped_request) got = j;
      ctl_man = (j >= 60 && j <= 75) ? S_EW_YELLOW : S_NS_GREEN;
    end
    chk("t5_yellow_defer", 32'(got), 32'd77);
    ctl_man = S_PED_GREEN;
    repeat (3) tick();
    ctl_man = S_NS_GREEN;
    repeat (25) tick();

    // 6: reset in the middle of WALK
    btn = 4'b0011;
    np = 0;
    repeat (10) begin tick(); if (ped_request) np++; end
    btn = '0;
    chk("t6_pulses", 32'(np), 32'd1);
    ctl_man = S_PED_GREEN;
    repeat (3) tick();
    chk("t6_walk", 32'(walk_active), 32'd1);
    chk("t6_pend", 32'(pending), 32'b0011);
    reset = 1'b1;
    tick();
    chk("t6_ped_request", 32'(ped_request), 32'd0);
    chk("t6_pending",     32'(pending), 32'd0);
    chk("t6_served",      32'(served), 32'd0);
    chk("t6_walk_active", 32'(walk_active), 32'd0);
    chk("t6_cooldown",    32'(cooldown), 32'd0);
    reset = 1'b0;
    ctl_man = S_NS_GREEN;
    tick();

    // random traffic: button presses of random length, random controller,
    // occasional one-cycle resets
    for (int i = 0; i < N; i++) hold[i] = 0;
    auto_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (hold[i] > 0) begin
          hold[i]--;
          if (hold[i] == 0) btn[i] = 1'b0;
        end else if ($urandom_range(0, 39) == 0) begin
          btn[i] = 1'b1;
          hold[i] = $urandom_range(1, 12);
        end
      end
      reset = ($urandom_range(0, 799) == 0);
      tick();
    end
    reset = 1'b0;
    btn = '0;
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
